// File: rtl/stall_ctrl_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : stall_ctrl_pkg
// | Description : Pipeline-wide constants shared by the hazard/stall logic.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package stall_ctrl_pkg;

    // Tuse/Tnew are 2-bit cycle counts; the value 3 marks an operand that is never read.
    typedef logic [1:0] tcyc_t;

    localparam tcyc_t       c_T_NEVER          = 2'd3;
    localparam int          c_MULT_CYCLES_DEF  = 5;
    localparam int          c_DIV_CYCLES_DEF   = 10;
    localparam logic [4:0]  c_REG_ZERO         = 5'd0;

endpackage : stall_ctrl_pkg

`default_nettype wire

// File: rtl/stall_ctrl_md_busy_timer.sv
// +-----------------------------------------------------------------------------
// | Module      : md_busy_timer
// | Description : Down-counter that tracks how long the HI/LO unit stays busy.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module md_busy_timer
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam int c_CNT_W = $clog2(DIV_CYCLES + 1);

    logic [c_CNT_W-1:0] r_md_cnt;
    logic               w_load;

    // A start while already counting is dropped so the running window is never extended.
    assign w_load = i_start && (r_md_cnt == '0);
    assign o_busy = (r_md_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (w_load) begin
            r_md_cnt <= i_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

endmodule : md_busy_timer

`default_nettype wire

// File: rtl/stall_ctrl.sv
// +-----------------------------------------------------------------------------
// | Module      : stall_ctrl
// | Description : Data/multiply-divide hazard detection, stall/flush and stall counter.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_waddr,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_waddr,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        w_rs_hz;
    logic        w_rt_hz;
    logic        w_md_hz;
    logic        w_stall;
    logic        w_md_busy;
    logic [31:0] r_stall_cnt;

    // The $0 guard covers writers targeting $0 too, since a source of $0 always reads zero.
    assign w_rs_hz = (D_rs != c_REG_ZERO) &&
                     (((D_rs == E_waddr) && (D_tuse_rs < E_tnew)) ||
                      ((D_rs == M_waddr) && (D_tuse_rs < M_tnew)));

    assign w_rt_hz = (D_rt != c_REG_ZERO) &&
                     (((D_rt == E_waddr) && (D_tuse_rt < E_tnew)) ||
                      ((D_rt == M_waddr) && (D_tuse_rt < M_tnew)));

    assign w_md_hz = D_is_md && (w_md_busy || E_md_start);
    assign w_stall = w_rs_hz || w_rt_hz || w_md_hz;

    assign stall     = w_stall;
    assign flush_E   = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .i_start (E_md_start),
        .i_div   (E_md_div),
        .o_busy  (w_md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule : stall_ctrl

`default_nettype wire

// File: tb/tb_stall_ctrl.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_stall_ctrl
// | Description : Scoreboard bench for stall_ctrl with directed hazard vectors.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt;
    logic [1:0]  D_tuse_rs, D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_waddr, M_waddr;
    logic [1:0]  E_tnew, M_tnew;
    logic        E_md_start, E_md_div;
    logic        stall, flush_E, md_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Expected {stall, md_busy, stall_cnt} per cycle plus a tag naming the vector.
    logic [33:0] q_exp[$];
    string       q_name[$];
    logic [33:0] m_exp;
    string       m_name;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_waddr    (E_waddr),
        .E_tnew     (E_tnew),
        .M_waddr    (M_waddr),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: every expectation queued during the current cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            chk(m_name, "stall",     {31'd0, stall},   {31'd0, m_exp[33]});
            chk(m_name, "flush_E",   {31'd0, flush_E}, {31'd0, m_exp[33]});
            chk(m_name, "md_busy",   {31'd0, md_busy}, {31'd0, m_exp[32]});
            chk(m_name, "stall_cnt", stall_cnt,        m_exp[31:0]);
        end
    end

    // The pipeline never starts a mult/div while the unit is busy.
    always @(posedge clk) begin
        if (reset && E_md_start && md_busy) begin
            errors++;
            $display("FAIL md_restart actual=start_while_busy required=no_start");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_cycle(input string nm, input logic e_stall, input logic e_busy, input logic [31:0] e_cnt);
        q_exp.push_back({e_stall, e_busy, e_cnt});
        q_name.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        D_rs = 5'd0;  D_rt = 5'd0;
        D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md = 1'b0;
        E_waddr = 5'd0; E_tnew = 2'd0;
        M_waddr = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Hazard logic stays live during reset while counters are held at zero.
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_cycle("rst_comb", 1'b1, 1'b0, 32'd0);
        clear_inputs();
        reset = 1'b1;
        expect_cycle("idle", 1'b0, 1'b0, 32'd0);

        // Load-use through EX, then MEM, then resolved.
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_cycle("lu_e", 1'b1, 1'b0, 32'd0);
        E_tnew = 2'd0; M_waddr = 5'd8; M_tnew = 2'd1;
        expect_cycle("lu_m", 1'b1, 1'b0, 32'd1);
        M_tnew = 2'd0;
        expect_cycle("lu_clr", 1'b0, 1'b0, 32'd2);

        // rt path and the Tuse == Tnew boundary.
        clear_inputs();
        D_rt = 5'd9; D_tuse_rt = 2'd1; E_waddr = 5'd9; E_tnew = 2'd2;
        expect_cycle("rt_e", 1'b1, 1'b0, 32'd2);
        D_tuse_rt = 2'd2;
        expect_cycle("rt_eq", 1'b0, 1'b0, 32'd3);

        // $0 never hazards.
        clear_inputs();
        D_rs = 5'd0; D_tuse_rs = 2'd0; E_waddr = 5'd0; E_tnew = 2'd2;
        D_rt = 5'd0; D_tuse_rt = 2'd0; M_waddr = 5'd0; M_tnew = 2'd2;
        expect_cycle("zero", 1'b0, 1'b0, 32'd3);

        // Divide: stall on the start cycle plus ten busy cycles.
        clear_inputs();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1;
        expect_cycle("div_start", 1'b1, 1'b0, 32'd3);
        E_md_start = 1'b0; E_md_div = 1'b0;
        for (int k = 1; k <= 10; k++)
            expect_cycle($sformatf("div_busy%0d", k), 1'b1, 1'b1, 32'd3 + 32'(k));
        expect_cycle("div_done", 1'b0, 1'b0, 32'd14);

        // Data hazard and md hazard together count once.
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_waddr = 5'd8; E_tnew = 2'd2;
        E_md_start = 1'b1; E_md_div = 1'b0;
        expect_cycle("both", 1'b1, 1'b0, 32'd14);
        clear_inputs();
        D_is_md = 1'b1;
        expect_cycle("mul_b1", 1'b1, 1'b1, 32'd15);
        expect_cycle("mul_b2", 1'b1, 1'b1, 32'd16);

        // Reset between edges clears the busy window and counter without a clock.
        reset = 1'b0;
        expect_cycle("rst_mid", 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        expect_cycle("post_rst", 1'b0, 1'b0, 32'd0);

        // Saturation from a preloaded counter.
        clear_inputs();
        dut.r_stall_cnt = 32'hFFFF_FFFE;
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_cycle("sat0", 1'b1, 1'b0, 32'hFFFF_FFFE);
        expect_cycle("sat1", 1'b1, 1'b0, 32'hFFFF_FFFF);
        expect_cycle("sat2", 1'b1, 1'b0, 32'hFFFF_FFFF);
        clear_inputs();
        expect_cycle("sat_hold", 1'b0, 1'b0, 32'hFFFF_FFFF);

        for (int w = 0; w < 5 && q_exp.size() > 0; w++)
            @(negedge clk);
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stall_ctrl

`default_nettype wire

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for div/divu.
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- D_rs, D_rt  in  5 each  source registers of the instruction in ID.
- D_tuse_rs, D_tuse_rt  in  2 each  cycles until ID needs rs/rt (0..2; 3 = unused).
- D_is_md  in  1  ID holds mult/div/mfhi/mflo/mthi/mtlo.
- E_waddr  in  5  EX destination register.
- E_tnew  in  2  cycles until the EX result is ready.
- M_waddr  in  5  MEM destination register.
- M_tnew  in  2  cycles until the MEM result is ready.
- E_md_start  in  1  EX holds mult/multu/div/divu this cycle.
- E_md_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  freezes PC and the IF/ID register (drives its stop_sel).
- flush_E  out  1  inserts a bubble into the ID/EX register at the next edge.
- md_busy  out  1  the HI/LO unit is computing.
- stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-004 rs_hz SHALL equal (D_rs!=0) AND ((D_rs==E_waddr AND D_tuse_rs<E_tnew) OR (D_rs==M_waddr AND D_tuse_rs<M_tnew)); rt_hz SHALL be the same with rt.
REQ-005 md_hz SHALL equal D_is_md AND (md_busy OR E_md_start).
REQ-006 stall SHALL equal rs_hz OR rt_hz OR md_hz, combinational, in the same cycle (0 latency).
REQ-007 flush_E SHALL equal stall; no other flush source exists in this block.
REQ-008 Register $0 SHALL never cause a hazard, even when E_waddr==0 or M_waddr==0.
REQ-009 The block SHALL contain an internal counter md_cnt of width clog2(DIV_CYCLES+1); md_busy SHALL equal (md_cnt!=0).
REQ-010 At a posedge with E_md_start=1 and md_cnt==0, md_cnt SHALL load DIV_CYCLES if E_md_div=1, else MULT_CYCLES.
REQ-011 At a posedge where no load occurs and md_cnt!=0, md_cnt SHALL decrement by 1; md_busy is therefore high for exactly N cycles after the start cycle.
REQ-012 E_md_start while md_cnt!=0 SHALL be ignored (no reload); the pipeline makes this unreachable and verification checks it by assertion.
REQ-013 stall_cnt SHALL increment by 1 at each posedge where stall=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-014 Both hazards present in the same cycle SHALL produce a single stall; stall_cnt increments by 1, not 2.

Reset
REQ-015 While reset=0, md_cnt and stall_cnt SHALL be 0 immediately, without waiting for a clock edge; md_busy is then 0.
REQ-016 Reset mid-computation SHALL abort the busy window; after reset is released, md_busy=0.
REQ-017 During reset, stall and flush_E SHALL still follow REQ-006/007 combinationally, with md_busy=0.

Structure
REQ-018 The Tuse/Tnew encoding (2-bit, 3 = never used), MULT_CYCLES/DIV_CYCLES defaults, and register $0 constant SHALL live in a shared pipeline package.
REQ-019 The block SHALL have one sub-module, md_busy_timer (md_cnt, load, decrement); the hazard compare SHALL be inline.

Verification
REQ-020 Load-use: D_rs=8, D_tuse_rs=0, E_waddr=8, E_tnew=2 -> stall=1, flush_E=1; next cycle with E_tnew=0, M_waddr=8, M_tnew=1 -> stall=1; with M_tnew=0 -> stall=0.
REQ-021 $0 filter: D_rs=0, D_tuse_rs=0, E_waddr=0, E_tnew=2 -> stall=0.
REQ-022 Divide: E_md_start=1, E_md_div=1 for one cycle, D_is_md=1 held -> md_busy=1 for exactly 10 cycles, stall=1 for 11 cycles (start cycle plus 10), stall_cnt=11.
REQ-023 Multiply then reset: E_md_start=1, E_md_div=0; reset=0 asserted 2 cycles later between edges -> md_busy=0 and stall_cnt=0 immediately.
REQ-024 Saturation: stall_cnt preloaded to FFFF_FFFE, stall held 3 cycles -> stall_cnt=FFFF_FFFF and stays there.
REQ-025 Simultaneous hazards: rs_hz and md_hz both true in one cycle -> stall=1, stall_cnt +1.
